// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_wait_timer.sv
// Wait-state counter for one port transaction. It restarts on each grant and
// flags expiry on the MAX_WAIT-th busy cycle that ends without an ack.
module arb_wait_timer #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic busy,
  input  logic ack,
  output logic expire
);

  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] wait_cnt;

  assign expire = busy & ~ack & (wait_cnt == LAST);

  // Count unacknowledged busy cycles; restart on grant and after expiry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (start || expire) begin
      wait_cnt <= '0;
    end else if (busy && !ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and data requesters. The data side
// has priority. Completed responses are held until the pipeline advances, and a
// fetch that is flushed while in flight is drained and its data dropped.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wsel,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wsel,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic [DATA_W-1:0]   if_rdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                stall_pipl,
  output logic                bus_err
);

  arb_state_t        state;
  logic              if_done;
  logic              dm_done;
  logic              kill;

  logic              expire;
  logic              data_ack;
  logic              fetch_ack;
  logic              fetch_keep;
  logic              if_done_a;
  logic              dm_done_a;
  logic              grant_dm;
  logic              grant_if;
  logic              can_grant;
  logic              start;
  logic [DATA_W-1:0] rdata_ev;

  assign stall_pipl = (if_req & ~if_done) | (dm_req & ~dm_done);

  // Completion events and the grant decision. The grant looks at the done
  // flags as they stand after this cycle's completion, so a second
  // transaction can follow an ack without an idle cycle.
  always_comb begin
    data_ack   = 1'b0;
    fetch_ack  = 1'b0;
    fetch_keep = 1'b0;
    rdata_ev   = '0;
    dm_done_a  = 1'b0;
    if_done_a  = 1'b0;
    grant_dm   = 1'b0;
    grant_if   = 1'b0;
    can_grant  = 1'b0;
    start      = 1'b0;

    data_ack   = (state == DATA)  & (mem_ack | expire);
    fetch_ack  = (state == FETCH) & (mem_ack | expire);
    // A flush in the ack cycle makes the returned instruction stale.
    fetch_keep = fetch_ack & ~kill & ~flush;
    rdata_ev   = mem_ack ? mem_rdata : '0;

    dm_done_a  = dm_done | data_ack;
    if_done_a  = (if_done | fetch_keep) & ~flush;

    grant_dm   = dm_req & ~dm_done_a;
    grant_if   = if_req & ~if_done_a;
    can_grant  = (state == IDLE) | data_ack | fetch_ack;
    start      = can_grant & (grant_dm | grant_if);
  end

  arb_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .busy    (state != IDLE),
    .ack     (mem_ack),
    .expire  (expire)
  );

  // Arbiter FSM with registered port outputs, response holding and done flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wsel  <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      bus_err   <= 1'b0;
      kill      <= 1'b0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
    end else begin
      bus_err <= expire;

      // With no stall the pipeline advances, so held results are consumed.
      if (!stall_pipl) begin
        if_done <= 1'b0;
        dm_done <= 1'b0;
      end else begin
        if_done <= if_done_a;
        dm_done <= dm_done_a;
      end

      if (fetch_ack) begin
        kill <= 1'b0;
      end else if (flush && state == FETCH) begin
        kill <= 1'b1;
      end

      if (data_ack && !mem_we) begin
        dm_rdata <= rdata_ev;
      end
      if (fetch_keep) begin
        if_rdata <= rdata_ev;
      end

      if (can_grant) begin
        if (grant_dm) begin
          state     <= DATA;
          mem_req   <= 1'b1;
          mem_we    <= dm_we;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
          mem_wsel  <= dm_wsel;
        end else if (grant_if) begin
          state     <= FETCH;
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_wsel  <= '0;
        end else begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single shared memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage load/store). It raises `stall_pipl` toward the pipeline controller until every active request has been served. Completed responses are held in registers until the pipeline advances. A fetch still in flight when the front end is flushed is drained, and its data is discarded. The block sits between the IF/MEM stages, the pipeline controller and the memory bus interface.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 255, cycles without `mem_ack` before a transaction is aborted (≥1)

- `clk` in 1: core clock
- `reset_n` in 1: synchronous, active-low reset
- `if_req` in 1: fetch requested this cycle
- `if_addr` in ADDR_W: fetch address (PC)
- `dm_req` in 1: load/store requested this cycle
- `dm_we` in 1: store when 1
- `dm_addr` in ADDR_W: data address
- `dm_wdata` in DATA_W: store data
- `dm_wsel` in DATA_W/8: byte enables
- `flush` in 1: front-end flush (branch hazard, mret or interrupt)
- `mem_req` out 1: port transaction active
- `mem_we` out 1: write strobe
- `mem_addr` out ADDR_W: port address
- `mem_wdata` out DATA_W: port write data
- `mem_wsel` out DATA_W/8: port byte enables
- `mem_rdata` in DATA_W: read data, valid with `mem_ack`
- `mem_ack` in 1: transaction complete
- `if_rdata` out DATA_W: held instruction
- `dm_rdata` out DATA_W: held load data
- `stall_pipl` out 1: pipeline must hold
- `bus_err` out 1: one-cycle pulse on timeout

## Operation
- **FSM states.** IDLE, DATA, FETCH.
- **Grant from IDLE.** Grant goes to `dm_req & ~dm_done` first, else `if_req & ~if_done`.
  - On grant, `mem_addr`, `mem_we`, `mem_wdata` and `mem_wsel` are registered.
  - All four are held stable until ack or abort.
  - `mem_we` is 0 for a fetch.
- **`mem_req`.** Asserted (registered) in DATA and FETCH, deasserted in IDLE.
- **On `mem_ack` in DATA.** `dm_rdata` ← `mem_rdata` (unchanged for a store), and `dm_done` is set.
- **On `mem_ack` in FETCH.** If `kill`=0: `if_rdata` ← `mem_rdata` and `if_done` is set. If `kill`=1: data is dropped and `kill` is cleared.
- **After ack.** The next grant is evaluated in the same cycle using the updated done flags, so back-to-back transactions are allowed. If nothing is pending, the next state is IDLE.
- **Stall.** `stall_pipl` = (`if_req` & ~`if_done`) | (`dm_req` & ~`dm_done`). It is combinational, from registered flags only.
- **Advance.** A cycle with `stall_pipl`=0 clears both done flags.
- **`flush`.**
  - Clears `if_done`.
  - Sets `kill` if the state is FETCH and no ack occurs in the same cycle.
  - Has no effect on DATA or `dm_done`.
- **Timeout.** `wait_cnt` increments each DATA/FETCH cycle without ack and resets on grant. When `wait_cnt` = MAX_WAIT−1 and there is no ack:
  - `bus_err` pulses.
  - The transaction is treated as acked with rdata = 0. A killed fetch is simply dropped.
- **Reset values.**
  - FSM: IDLE.
  - `mem_req`, `mem_we`, `bus_err`, `kill`, `if_done`, `dm_done`, `wait_cnt`: 0.
  - `mem_addr`, `mem_wdata`, `mem_wsel`, `if_rdata`, `dm_rdata`: 0.
  - `stall_pipl` therefore follows the requests.

## Timing
- **Zero-wait memory (ack in the first cycle of `mem_req`).**
  - Grant at cycle N, `mem_req` high at N+1, ack at N+1.
  - Done flag and rdata visible at N+2, so `stall_pipl` drops at N+2.
- **Fetch plus data, both zero-wait.** DATA at N+1, FETCH at N+2, stall drops at N+3.
- **Reset mid-transaction.** All state is discarded. A late `mem_ack` arriving in IDLE is ignored.
- **Requester behaviour.** A requester must keep request and address stable while `stall_pipl`=1. Exception: `if_addr` may change in the cycle `flush` is high.
- **Flush coinciding with fetch ack.** The ack is consumed, `if_done` stays 0, and the new PC is fetched next.

## Structure
- **Package `mem_arb_pkg`.** Holds the `arb_state_t` enum {IDLE, DATA, FETCH} and the default `ADDR_W`/`DATA_W` localparams.
- **Sub-module `arb_wait_timer`.** Parameterised MAX_WAIT counter with inputs `start`, `ack` and output `expire`. All other logic is a single module.

## Test plan
- **Fetch only, zero-wait.** `if_req`=1, addr 0x100, ack on the first `mem_req` cycle, rdata 0x00000013. Expect `if_rdata`=0x13, and `stall_pipl` 1 for 2 cycles then 0.
- **Simultaneous data and fetch.** Store to 0x2000, wsel 0xF, wdata 0xDEADBEEF. Expect the port to carry the store first (`mem_we`=1), then the fetch, and `stall_pipl` to fall on cycle 3.
- **Flush during a 3-wait fetch.** Expect `kill` set and the ack dropped. A new fetch of 0x200 issues after the ack, and `if_rdata` reflects only 0x200's data.
- **Timeout.** Load with no ack for MAX_WAIT cycles. Expect one `bus_err` pulse, `dm_rdata`=0, then stall release.
- **Reset mid-DATA.** Assert `reset_n`=0 for 1 cycle. Expect all outputs at their reset values, and a following stray `mem_ack` has no effect.
- **Load with a 2-cycle wait while the fetch is already done.** Expect `stall_pipl` held until `dm_done`, and `if_rdata` unchanged throughout.
